dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Controller for the single-port data memory behind the MEM stage. It shares the memory between the pipeline MEM stage, which has priority, and the debug unit, which issues single-word reads/writes and full-memory dump bursts. The block sits between the EX/MEM-driven MEM stage and the data-memory array. When a debug request is starved, it raises a one-cycle pipeline stall.

## Interface
- ADDR_W, 8, word-index width; memory depth = 2^ADDR_W words
- DATA_W, 32, data width
- STARVE_LIMIT, 4, debug-wait cycles before forced stall; legal range 1..15
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-high
- pipe_mem_read  in  1  MEM-stage load
- pipe_mem_write  in  1  MEM-stage store
- pipe_addr  in  32  MEM-stage byte address (ALU result)
- pipe_wdata  in  DATA_W  store data
- pipe_rdata  out  DATA_W  load data (combinational)
- pipe_stall  out  1  freeze IF..EX/MEM this cycle (combinational)
- dbg_req  in  1  single-access request, held until ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  word index
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack
- dbg_dump_start  in  1  pulse: dump the whole memory
- dbg_dump_valid  out  1  dump word available
- dbg_dump_data  out  DATA_W  dump word
- dbg_dump_ready  in  1  consumer accepts word
- dbg_dump_done  out  1  one-cycle pulse after last word accepted
- mem_addr  out  ADDR_W  memory word index (combinational)
- mem_we  out  1  memory write enable, sampled at posedge clk
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  asynchronous memory read data

## Operation
- pipe_active = pipe_mem_read | pipe_mem_write.
- dbg_want is high in either case: state IDLE with dbg_req, or state DUMP with the dump buffer empty.
- starve_cnt:
  - increments while dbg_want & pipe_active;
  - clears on every debug win;
  - saturates at STARVE_LIMIT.
- Debug win = dbg_want & (!pipe_active | starve_cnt == STARVE_LIMIT). On a forced win, pipe_stall = 1 for that cycle only.
- Port mux:
  - On a debug win, the memory port is driven by dbg_addr / dbg_we / dbg_wdata, or by dump_ptr with we = 0.
  - Otherwise mem_addr = pipe_addr[ADDR_W+1:2] and mem_we = pipe_mem_write.
  - pipe_rdata = mem_rdata when pipe_mem_read & !pipe_stall, else 0.
- FSM states: IDLE, SINGLE_ACK, DUMP, DONE.
  - IDLE: dbg_dump_start → DUMP with dump_ptr = 0. dbg_dump_start has priority over a same-cycle dbg_req, which waits.
  - IDLE: a debug win on dbg_req performs the access, captures mem_rdata into dbg_rdata, and moves to SINGLE_ACK. A write leaves dbg_rdata unchanged.
  - SINGLE_ACK: dbg_ack = 1, then IDLE. The requester drops dbg_req in the ack cycle; a still-high req in IDLE starts a new access.
  - DUMP, buffer empty, debug win: capture mem_rdata[dump_ptr] into dbg_dump_data and set dbg_dump_valid.
  - DUMP, valid & ready: clear valid. If dump_ptr == 2^ADDR_W−1, go to DONE; otherwise dump_ptr++ and wrap is never reached.
  - DONE: dbg_dump_done = 1, then IDLE.
- dbg_dump_start outside IDLE is ignored.
- Pipeline writes during a dump are not blocked; a word already buffered is not refreshed.

## Timing
- Single access latency: grant cycle + 1; dbg_ack occurs the cycle after the win. Minimum is 2 cycles from dbg_req rising.
- Worst-case debug wait under continuous pipeline traffic: STARVE_LIMIT cycles, then the win.
- Dump: first word valid 1 cycle after the first win. Maximum throughput is one word per 2 cycles (buffer refill after accept).
- dbg_dump_done fires the cycle after the final accept.
- Reset (synchronous), registered outputs cleared:
  - state = IDLE;
  - starve_cnt, dump_ptr = 0;
  - dbg_ack, dbg_rdata, dbg_dump_valid, dbg_dump_data, dbg_dump_done = 0.
- Reset in the reset cycle: pipe_stall = 0 and mem_we = pipe_mem_write.
- Reset mid-dump or mid-ack aborts silently, with no done or ack pulse.

## Structure
- Shared mips_pkg.vh: DMEM_ADDR_W, state encodings (ARB_IDLE, ARB_SINGLE_ACK, ARB_DUMP, ARB_DONE).
- Single module. The starvation counter is small enough to stay inline; no sub-module.

## Test plan
- Pipeline idle, dbg_req read at addr 5 (mem[5] = 0x1234) → dbg_ack in the next cycle, dbg_rdata = 0x1234, pipe_stall never high.
- Continuous pipe_mem_read with dbg_req write 0xCAFE @ addr 3, STARVE_LIMIT = 4 → pipe_stall high exactly at the 5th cycle, mem[3] = 0xCAFE, pipe_rdata = 0 in that cycle.
- Pipeline store to byte 0x10 and dbg_req in the same cycle → mem[4] written by the pipeline, debug served in the next idle cycle.
- Dump with ADDR_W = 3, mem[i] = i + 100, dbg_dump_ready always 1 → words 100..107 in order, dbg_dump_done once, 16 cycles total.
- Dump with ready held low for 10 cycles on word 2 → dbg_dump_data stable at 102, dbg_dump_valid held, no pointer advance.
- Reset asserted mid-dump at word 4 → outputs zero next cycle, no done pulse, and a new dbg_dump_start restarts from word 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_SINGLE_ACK = 2'd1,
    ARB_DUMP       = 2'd2,
    ARB_DONE       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and the
// debug unit (single accesses and full-memory dumps), with starvation-forced stalls.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_mem_read,
  input  logic              pipe_mem_write,
  input  logic [31:0]       pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_dump_start,
  output logic              dbg_dump_valid,
  output logic [DATA_W-1:0] dbg_dump_data,
  input  logic              dbg_dump_ready,
  output logic              dbg_dump_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  arb_state_e        state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] dump_ptr, ptr_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic [DATA_W-1:0] dump_data_q, dump_data_nxt;
  logic              dump_valid_q, valid_nxt;
  logic              pipe_active, dbg_want, dbg_win;
  logic              unused_pipe_addr;

  assign pipe_active      = pipe_mem_read | pipe_mem_write;
  assign unused_pipe_addr = ^{pipe_addr[31:ADDR_W+2], pipe_addr[1:0]};

  // A pending dump start outranks a same-cycle single request, so that
  // request is not yet wanting the port and does not age the counter.
  always_comb begin
    dbg_want = 1'b0;
    if (state == ARB_IDLE)      dbg_want = dbg_req & ~dbg_dump_start;
    else if (state == ARB_DUMP) dbg_want = ~dump_valid_q;
    dbg_win = ~reset & dbg_want & (~pipe_active | (starve_cnt == LIMIT));
  end

  always_comb begin
    pipe_stall = dbg_win & pipe_active;
    mem_addr   = pipe_addr[ADDR_W+1:2];
    mem_we     = pipe_mem_write;
    mem_wdata  = pipe_wdata;
    if (dbg_win) begin
      if (state == ARB_DUMP) begin
        mem_addr = dump_ptr;
        mem_we   = 1'b0;
      end else begin
        mem_addr  = dbg_addr;
        mem_we    = dbg_we;
        mem_wdata = dbg_wdata;
      end
    end
    pipe_rdata = (pipe_mem_read & ~pipe_stall) ? mem_rdata : '0;
  end

  // Dump stream: a word transfers on a cycle where dbg_dump_valid and
  // dbg_dump_ready are both high; valid never drops and data never changes
  // while waiting for ready. The buffer refills only after it empties.
  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    ptr_nxt       = dump_ptr;
    valid_nxt     = dump_valid_q;
    dump_data_nxt = dump_data_q;
    rdata_nxt     = rdata_q;

    if (dbg_win)
      starve_nxt = '0;
    else if (dbg_want & pipe_active & (starve_cnt != LIMIT))
      starve_nxt = starve_cnt + 4'd1;

    case (state)
      ARB_IDLE: begin
        if (dbg_dump_start) begin
          state_nxt = ARB_DUMP;
          ptr_nxt   = '0;
          valid_nxt = 1'b0;
        end else if (dbg_win) begin
          state_nxt = ARB_SINGLE_ACK;
          if (!dbg_we) rdata_nxt = mem_rdata;
        end
      end
      ARB_SINGLE_ACK: state_nxt = ARB_IDLE;
      ARB_DUMP: begin
        if (dump_valid_q) begin
          if (dbg_dump_ready) begin
            valid_nxt = 1'b0;
            if (dump_ptr == LAST_PTR) state_nxt = ARB_DONE;
            else                      ptr_nxt   = dump_ptr + 1'b1;
          end
        end else if (dbg_win) begin
          dump_data_nxt = mem_rdata;
          valid_nxt     = 1'b1;
        end
      end
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      starve_cnt   <= '0;
      dump_ptr     <= '0;
      rdata_q      <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      dump_ptr     <= ptr_nxt;
      rdata_q      <= rdata_nxt;
      dump_data_q  <= dump_data_nxt;
      dump_valid_q <= valid_nxt;
    end
  end

  assign dbg_ack        = (state == ARB_SINGLE_ACK);
  assign dbg_dump_done  = (state == ARB_DONE);
  assign dbg_rdata      = rdata_q;
  assign dbg_dump_valid = dump_valid_q;
  assign dbg_dump_data  = dump_data_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with an 8-word memory model.
module tb_dmem_port_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_mem_read, pipe_mem_write;
  logic [31:0]   pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          pipe_stall;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_dump_start, dbg_dump_valid, dbg_dump_ready, dbg_dump_done;
  logic [DW-1:0] dbg_dump_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:7];
  logic          preload;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  exp_addr;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dbg_dump_start(dbg_dump_start), .dbg_dump_valid(dbg_dump_valid),
    .dbg_dump_data(dbg_dump_data), .dbg_dump_ready(dbg_dump_ready),
    .dbg_dump_done(dbg_dump_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'(i + 100);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_dump();
    dbg_dump_start = 1'b1;
    dbg_dump_ready = 1'b1;
    tick();
    dbg_dump_start = 1'b0;
  endtask

  int widx, hold, done_cnt, done_s;
  logic found;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h14, 32'h0,    3'd5, 1'b0, 32'd105};
    vecs[1] = '{1'b1, 1'b0, 32'h1C, 32'h0,    3'd7, 1'b0, 32'd107};
    vecs[2] = '{1'b0, 1'b1, 32'h08, 32'hAAAA, 3'd2, 1'b1, 32'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h08, 32'h0,    3'd2, 1'b0, 32'hAAAA};
    vecs[4] = '{1'b0, 1'b0, 32'h0C, 32'h0,    3'd3, 1'b0, 32'd0};
    vecs[5] = '{1'b1, 1'b0, 32'h23, 32'h0,    3'd0, 1'b0, 32'd100};

    reset = 1'b1; preload = 1'b1;
    pipe_mem_read = 0; pipe_mem_write = 0; pipe_addr = 0; pipe_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    dbg_dump_start = 0; dbg_dump_ready = 0;
    tick(); tick();
    preload = 1'b0;

    // reset cycle: pipeline store passes, debug held off
    pipe_mem_write = 1'b1; pipe_addr = 32'h4; pipe_wdata = 32'd101; dbg_req = 1'b1;
    #1;
    check("reset_stall", pipe_stall, 0);
    check("reset_mem_we", mem_we, 1);
    check("reset_mem_addr", mem_addr, 1);
    tick();
    reset = 1'b0; pipe_mem_write = 0; pipe_addr = 0; dbg_req = 0;
    check("reset_ack", dbg_ack, 0);
    check("reset_rdata", dbg_rdata, 0);
    check("reset_dump_valid", dbg_dump_valid, 0);
    check("reset_dump_data", dbg_dump_data, 0);
    check("reset_dump_done", dbg_dump_done, 0);

    // table-driven pipeline port mux
    for (int i = 0; i < 6; i++) begin
      pipe_mem_read = vecs[i].rd; pipe_mem_write = vecs[i].wr;
      pipe_addr = vecs[i].addr; pipe_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_pipe_rdata", i), pipe_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i), pipe_stall, 0);
      if (vecs[i].wr) check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      tick();
    end
    pipe_mem_read = 0; pipe_mem_write = 0; pipe_addr = 0;

    // single debug read with idle pipeline
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd5;
    #1;
    check("rd_stall", pipe_stall, 0);
    check("rd_mem_addr", mem_addr, 5);
    tick();
    dbg_req = 1'b0;
    check("rd_ack", dbg_ack, 1);
    check("rd_rdata", dbg_rdata, 32'd105);
    check("rd_ack_stall", pipe_stall, 0);
    tick();
    check("rd_ack_drop", dbg_ack, 0);

    // starvation under continuous loads forces one stall on the 5th cycle
    pipe_mem_read = 1'b1; pipe_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd3; dbg_wdata = 32'hCAFE;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("starve_c%0d_stall", k), pipe_stall, 32'(k == 5));
      if (k == 5) begin
        check("starve_pipe_rdata", pipe_rdata, 0);
        check("starve_mem_addr", mem_addr, 3);
        check("starve_mem_we", mem_we, 1);
        check("starve_mem_wdata", mem_wdata, 32'hCAFE);
      end else begin
        check($sformatf("starve_c%0d_pipe_rdata", k), pipe_rdata, 32'd101);
      end
      tick();
    end
    check("starve_ack", dbg_ack, 1);
    check("starve_mem3", mem[3], 32'hCAFE);
    dbg_req = 1'b0;
    #1;
    check("starve_ack_stall", pipe_stall, 0);
    check("starve_ack_pipe_rdata", pipe_rdata, 32'd101);
    tick();
    pipe_mem_read = 1'b0;
    check("starve_ack_drop", dbg_ack, 0);

    // pipeline store and debug read collide; pipeline first
    pipe_mem_write = 1'b1; pipe_addr = 32'h10; pipe_wdata = 32'hBEEF;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd4;
    #1;
    check("coll_mem_we", mem_we, 1);
    check("coll_mem_addr", mem_addr, 4);
    check("coll_stall", pipe_stall, 0);
    tick();
    pipe_mem_write = 1'b0; pipe_addr = 0;
    check("coll_no_ack", dbg_ack, 0);
    check("coll_mem4", mem[4], 32'hBEEF);
    #1;
    check("coll_dbg_mem_we", mem_we, 0);
    check("coll_dbg_stall", pipe_stall, 0);
    tick();
    dbg_req = 1'b0;
    check("coll_ack", dbg_ack, 1);
    check("coll_rdata", dbg_rdata, 32'hBEEF);
    tick();

    // full dump, ready always high
    preload = 1'b1; tick(); preload = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i + 100));
    start_dump();
    check("dump_s1_valid", dbg_dump_valid, 0);
    widx = 0; done_cnt = 0; done_s = 0;
    for (int s = 2; s <= 22; s++) begin
      tick();
      if (dbg_dump_valid) begin
        if (exp_q.size() == 0) check("dump_extra_word", 1, 0);
        else check($sformatf("dump_w%0d", widx), dbg_dump_data, exp_q.pop_front());
        check($sformatf("dump_w%0d_cycle", widx), s, 2 + 2 * widx);
        widx++;
      end
      if (dbg_dump_done) begin
        done_cnt++;
        done_s = s;
      end
    end
    check("dump_words", widx, 8);
    check("dump_done_count", done_cnt, 1);
    check("dump_done_cycle", done_s, 17);

    // dump with ready held low for 10 cycles on word 2
    start_dump();
    widx = 0; hold = 0; done_cnt = 0;
    for (int s = 0; s < 60; s++) begin
      tick();
      if (dbg_dump_done) done_cnt++;
      if (dbg_dump_valid) begin
        check($sformatf("bp_w%0d", widx), dbg_dump_data, 32'(widx + 100));
        if (widx == 2 && hold < 10) begin
          dbg_dump_ready = 1'b0;
          hold++;
        end else begin
          dbg_dump_ready = 1'b1;
          widx++;
        end
      end else begin
        dbg_dump_ready = 1'b1;
      end
    end
    check("bp_words", widx, 8);
    check("bp_hold", hold, 10);
    check("bp_done_count", done_cnt, 1);

    // reset in the middle of a dump, then restart
    start_dump();
    found = 1'b0;
    for (int s = 0; s < 30 && !found; s++) begin
      tick();
      if (dbg_dump_valid && dbg_dump_data == 32'd104) found = 1'b1;
    end
    check("rst_reach_w4", found, 1);
    reset = 1'b1; dbg_dump_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_valid", dbg_dump_valid, 0);
    check("rst_data", dbg_dump_data, 0);
    check("rst_done", dbg_dump_done, 0);
    done_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (dbg_dump_done || dbg_dump_valid) done_cnt++;
    end
    check("rst_quiet", done_cnt, 0);
    start_dump();
    widx = 0; done_cnt = 0;
    for (int s = 0; s < 30; s++) begin
      tick();
      if (dbg_dump_valid) begin
        check($sformatf("rst_restart_w%0d", widx), dbg_dump_data, 32'(widx + 100));
        widx++;
      end
      if (dbg_dump_done) done_cnt++;
    end
    check("rst_restart_words", widx, 8);
    check("rst_restart_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
